// File: rtl/fft_frame_tx_pkg.sv
// Shared types and constants for the FFT sample framer.
// The CSUM state exists only when FFT_FRAME_TX_CHECKSUM_EN is defined.
package fft_tx_pkg;

   localparam int         SAMPLE_W         = 16;
   localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_FILL,
      ST_HDR,
      ST_DATA_HI,
      ST_DATA_LO
`ifdef FFT_FRAME_TX_CHECKSUM_EN
      , ST_CSUM
`endif
   } state_e;

endpackage

// File: rtl/fft_frame_tx_if.sv
// Sample-in / byte-out stream bundle; master is the framer side, slave the environment side.
interface fft_frame_tx_if;
   import fft_tx_pkg::*;

   logic [SAMPLE_W-1:0] s_data;
   logic                s_valid;
   logic                s_ready;
   logic [7:0]          m_data;
   logic                m_valid;
   logic                m_ready;
   logic                m_last;

   modport master (
      input  s_data, s_valid, m_ready,
      output s_ready, m_data, m_valid, m_last
   );

   modport slave (
      output s_data, s_valid, m_ready,
      input  s_ready, m_data, m_valid, m_last
   );

endinterface

// File: rtl/fft_frame_tx.sv
// Collects FRAME_SAMPLES 16-bit samples, then streams header + MSB/LSB bytes to the FFT core.
// Define FFT_FRAME_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module fft_frame_tx
   import fft_tx_pkg::*;
#(
   parameter int         FRAME_SAMPLES = 8,
   parameter logic [7:0] HDR_BYTE      = HDR_BYTE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   fft_frame_tx_if.master        bus,
   output logic [7:0]            frames_sent
);

   localparam int               IDX_W    = $clog2(FRAME_SAMPLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SAMPLES - 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q;
   logic [SAMPLE_W-1:0] sample_buf [FRAME_SAMPLES];
   logic                accept;
   logic                byte_hs;
   logic                last_idx;
   logic                idx_adv;
`ifdef FFT_FRAME_TX_CHECKSUM_EN
   logic [7:0]          csum_q;
`endif

   assign accept   = bus.s_valid && bus.s_ready;
   assign byte_hs  = bus.m_valid && bus.m_ready;
   assign last_idx = (idx_q == LAST_IDX);
   // One index serves both the fill write pointer and the transmit read pointer.
   assign idx_adv  = accept || (state_q == ST_DATA_LO && bus.m_ready);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_FILL;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d     = state_q;
      bus.s_ready = 1'b0;
      bus.m_valid = 1'b0;
      bus.m_data  = '0;
      bus.m_last  = 1'b0;
      case (state_q)
         ST_FILL: begin
            bus.s_ready = 1'b1;
            if (bus.s_valid && last_idx) state_d = ST_HDR;
         end
         ST_HDR: begin
            bus.m_valid = 1'b1;
            bus.m_data  = HDR_BYTE;
            if (bus.m_ready) state_d = ST_DATA_HI;
         end
         ST_DATA_HI: begin
            bus.m_valid = 1'b1;
            bus.m_data  = sample_buf[idx_q][SAMPLE_W-1:8];
            if (bus.m_ready) state_d = ST_DATA_LO;
         end
         ST_DATA_LO: begin
            bus.m_valid = 1'b1;
            bus.m_data  = sample_buf[idx_q][7:0];
`ifdef FFT_FRAME_TX_CHECKSUM_EN
            if (bus.m_ready) state_d = last_idx ? ST_CSUM : ST_DATA_HI;
`else
            bus.m_last  = last_idx;
            if (bus.m_ready) state_d = last_idx ? ST_FILL : ST_DATA_HI;
`endif
         end
`ifdef FFT_FRAME_TX_CHECKSUM_EN
         ST_CSUM: begin
            bus.m_valid = 1'b1;
            bus.m_data  = csum_q;
            bus.m_last  = 1'b1;
            if (bus.m_ready) state_d = ST_FILL;
         end
`endif
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q       <= '0;
         frames_sent <= '0;
`ifdef FFT_FRAME_TX_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         if (idx_adv) idx_q <= last_idx ? '0 : idx_q + IDX_W'(1);
         if (byte_hs && bus.m_last) frames_sent <= frames_sent + 8'd1;
`ifdef FFT_FRAME_TX_CHECKSUM_EN
         // Folded in at accept time so the CSUM byte is ready right after the last LSB.
         if (accept)                     csum_q <= csum_q ^ bus.s_data[SAMPLE_W-1:8] ^ bus.s_data[7:0];
         else if (byte_hs && bus.m_last) csum_q <= '0;
`endif
      end
   end

   // NOTE: the sample storage is deliberately not reset; restarting the index discards a partial frame.
   always_ff @(posedge clk) begin
      if (accept) sample_buf[idx_q] <= bus.s_data;
   end

endmodule

// File: tb/tb_fft_frame_tx.sv
// Randomized bench for fft_frame_tx against a frame-level byte-queue model.
// Follows FFT_FRAME_TX_CHECKSUM_EN to decide whether frames carry a checksum byte.
module tb_fft_frame_tx;

   localparam int         N   = 8;
   localparam logic [7:0] HDR = 8'hA5;
`ifdef FFT_FRAME_TX_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } byte_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] frames_sent;

   fft_frame_tx_if bus ();

   fft_frame_tx #(.FRAME_SAMPLES(N), .HDR_BYTE(HDR)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .frames_sent (frames_sent)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   byte_t       exp_q [$];
   logic [15:0] acc_q [$];
   logic [15:0] src_q [$];
   int          exp_frames  = 0;
   int          frame_bytes = 0;
   int          valid_cnt   = 0;
   bit          gap_en      = 1'b0;
   int          rdy_mode    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A full frame of accepted samples turns into its expected byte sequence.
   function automatic void push_frame();
      logic [7:0] cs = 8'h00;
      exp_q.push_back('{data: HDR, last: 1'b0});
      for (int i = 0; i < N; i++) begin
         exp_q.push_back('{data: acc_q[i][15:8], last: 1'b0});
         exp_q.push_back('{data: acc_q[i][7:0], last: (i == N - 1) && !CS_EN});
         cs = cs ^ acc_q[i][15:8] ^ acc_q[i][7:0];
      end
      if (CS_EN) exp_q.push_back('{data: cs, last: 1'b1});
      acc_q.delete();
   endfunction

   // Monitor and scoreboard, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            acc_q.delete();
            exp_frames  = 0;
            frame_bytes = 0;
         end else begin
            check("s_ready", bus.s_ready, exp_q.size() == 0);
            check("m_valid", bus.m_valid, exp_q.size() != 0);
            check("frames_sent", frames_sent, exp_frames);
            if (!bus.m_valid) check("m_last_idle", bus.m_last, 1'b0);
            if (bus.m_valid && exp_q.size() != 0) begin
               check("m_data", bus.m_data, exp_q[0].data);
               check("m_last", bus.m_last, exp_q[0].last);
               valid_cnt++;
               if (bus.m_ready) begin
                  frame_bytes++;
                  if (exp_q[0].last) begin
                     exp_frames  = (exp_frames + 1) % 256;
                     frame_bytes = 0;
                  end
                  void'(exp_q.pop_front());
               end
            end
            if (bus.s_valid && bus.s_ready) begin
               acc_q.push_back(bus.s_data);
               if (acc_q.size() == N) push_frame();
            end
         end
      end
   end

   // Sample source: holds s_valid until accepted, random data when idle.
   initial begin
      bit hs;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      forever begin
         @(negedge clk);
         hs = bus.s_valid && bus.s_ready && !rst;
         @(posedge clk);
         #1;
         if (hs && src_q.size() > 0) void'(src_q.pop_front());
         if (src_q.size() > 0 && (!gap_en || (bus.s_valid && !hs) || $urandom_range(0, 3) != 0)) begin
            bus.s_valid = 1'b1;
            bus.s_data  = src_q[0];
         end else begin
            bus.s_valid = 1'b0;
            bus.s_data  = 16'($urandom);
         end
      end
   end

   // Sink ready: always, a 1,0,0,1 pattern, or random.
   initial begin
      bit pat [4];
      int phase = 0;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      bus.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = pat[phase % 4];
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
         phase++;
      end
   end

   task automatic send_frame(input int kind);
      for (int i = 0; i < N; i++) begin
         case (kind)
            0:       src_q.push_back(16'(i + 1));
            1:       src_q.push_back(16'hBEEF);
            2:       src_q.push_back(16'h1234);
            default: src_q.push_back(16'($urandom));
         endcase
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while ((src_q.size() != 0 || acc_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
         @(posedge clk);
         k++;
      end
      check({tag, "_timeout"}, k < budget, 1'b1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_m_valid"}, bus.m_valid, 1'b0);
      check({tag, "_m_last"}, bus.m_last, 1'b0);
      check({tag, "_m_data"}, bus.m_data, 8'h00);
      check({tag, "_s_ready"}, bus.s_ready, 1'b1);
      check({tag, "_frames"}, frames_sent, 8'h00);
   endtask

   initial begin
      int k;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("rst");
      rst = 1'b0;

      // Ascending samples with a free-running sink: no bubbles allowed.
      valid_cnt = 0;
      send_frame(0);
      wait_idle("basic", 200);
      check("basic_len", valid_cnt, 2 * N + 1 + int'(CS_EN));
      check("basic_frames", frames_sent, 8'd1);

      rdy_mode = 1;
      send_frame(1);
      wait_idle("backpressure", 400);

      // Back-to-back frames with s_valid held high through transmit.
      rdy_mode = 2;
      repeat (3) send_frame(3);
      wait_idle("flow", 1000);

      gap_en = 1'b1;
      repeat (4) send_frame(3);
      wait_idle("random", 2000);

      // Reset after exactly five bytes of a frame have been consumed.
      gap_en = 1'b0;
      send_frame(3);
      k = 0;
      while (frame_bytes != 5 && k < 500) begin
         @(posedge clk);
         k++;
      end
      check("midrst_timeout", k < 500, 1'b1);
      #1;
      rst = 1'b1;
      src_q.delete();
      @(posedge clk);
      #1;
      check_reset_state("midrst");
      rst = 1'b0;

      rdy_mode = 0;
      send_frame(2);
      wait_idle("fresh", 200);
      check("fresh_frames", frames_sent, 8'd1);

      // Counter wrap: 255 then 256 frames since reset.
      repeat (254) send_frame(3);
      wait_idle("wrap255", 254 * 40);
      check("wrap_255", frames_sent, 8'hFF);
      send_frame(3);
      wait_idle("wrap256", 200);
      check("wrap_0", frames_sent, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
